ahb_cmd_arbiter: RTL and testbench
==================================

Name: ahb_cmd_arbiter

Overview:
- Two-requester command arbiter directly upstream of the AHB bus top; drives its din_*/dout_* user handshake.
- Selects one requester per command. Holds the grant for all beats of a fixed-length burst.
- Tags each accepted read in an in-order tag FIFO and routes returned read data back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, command address width.
- DATA_WIDTH, 32, write/read data width.
- TAG_DEPTH, 4, outstanding-read tag FIFO depth (power of two, >=2).

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- mN_vld_i  in  1  requester N (N=0,1) command valid
- mN_rdy_o  out  1  requester N command accepted
- mN_wr_en_i / mN_rd_en_i  in  1 each  write / read command
- mN_size_i  in  3  transfer size
- mN_burst_i  in  3  AHB burst code
- mN_addr_i  in  ADDR_WIDTH  address
- mN_wdata_i  in  DATA_WIDTH  write data
- mN_rsp_vld_o  out  1  read data valid to requester N
- mN_rdata_o  out  DATA_WIDTH  read data (shared bus, qualified by rsp_vld)
- mN_rsp_rdy_i  in  1  requester N accepts read data
- din_vld_o / din_rdy_i  out/in  1  command handshake to bus
- wr_en_o, rd_en_o, data_size_o[2:0], burst_o[2:0], addr_o, wdata_o  out  command fields of granted requester
- dout_vld_i / dout_rdy_o  in/out  1  read response handshake from bus
- rdata_i  in  DATA_WIDTH  read data from bus
- orphan_rsp_o  out  1  sticky: response arrived with empty tag FIFO

Behaviour:
- Reset: all mN_rdy_o, mN_rsp_vld_o, din_vld_o, orphan_rsp_o = 0; RR pointer = requester 0 preferred; lock counter = 0; tag FIFO empty. Reset mid-burst abandons the burst and clears all state.
- Arbitration, unlocked:
  - Round-robin between valid requesters.
  - After a grant completes, the other requester gets priority.
  - Grant is combinational from current valids and pointer, so a command can pass in the same cycle (zero added latency).
- Command handshake:
  - din_vld_o = granted mN_vld_i && !read_block. All command fields are muxed from the granted requester.
  - mN_rdy_o = granted && din_rdy_i && !read_block. The non-granted rdy is always 0.
  - Accept = din_vld_o && din_rdy_i.
- Read classification:
  - A command is a read when rd_en && !wr_en.
  - wr_en && rd_en is forwarded unchanged and treated as a write: no tag.
  - read_block = command is a read && tag FIFO full. Blocking applies even if a pop happens in the same cycle.
- Burst lock:
  - On an accept with burst 2/3 the lock counter loads 3; burst 4/5 loads 7; burst 6/7 loads 15. SINGLE(0) and INCR(1) load 0.
  - While the counter is nonzero, the grant is fixed to the locking requester. Each accept decrements the counter.
  - The other requester waits even if the locking requester drops valid.
  - RR pointer advances only when the counter reaches 0.
- Tag FIFO:
  - On a read accept, push the granted requester id.
  - Head id routes a response: mX_rsp_vld_o = dout_vld_i for X = head, 0 for the other. dout_rdy_o = mX_rsp_rdy_i.
  - On response handshake, pop.
  - Simultaneous push and pop keeps the count unchanged.
- Empty FIFO with dout_vld_i: dout_rdy_o = 1, data dropped, orphan_rsp_o set until reset.
- Writes produce no response.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid (burst lock still honoured); RR pointer logic removed.
- Undefined: round-robin as above.

Test Plan:
- Both requesters hold SINGLE writes, din_rdy_i=1: grants alternate m0,m1,m0,m1; 4 accepts in 4 cycles.
- m0 INCR4 write (burst=3) with m1 valid throughout: 4 consecutive m0 accepts, then m1. With din_rdy_i toggling 1/0 the lock still spans exactly 4 accepts.
- TAG_DEPTH=4, m0 issues 5 reads, no responses: 4 accepted, 5th sees m0_rdy_o=0. One response pop lets the 5th accept on the following cycle.
- Interleaved reads m0,m1,m0, responses 0xA,0xB,0xC: m0 gets 0xA, m1 gets 0xB, m0 gets 0xC. With m1_rsp_rdy_i held 0, dout_rdy_o=0 until released.
- dout_vld_i=1 after reset with no reads issued: dout_rdy_o=1, orphan_rsp_o=1, no mN_rsp_vld_o. Assert hresetn low mid-INCR8: lock cleared and both rdy 0 immediately.
- With ARB_FIXED_PRIO_EN: both valid continuously with SINGLE commands; m1 is never granted until m0_vld_i drops.

Source files
------------

// File: rtl/ahb_cmd_arbiter.sv
// Two-requester command arbiter in front of the AHB bus top: round-robin grant, burst lock,
// in-order read tag FIFO for response routing. Define ARB_FIXED_PRIO_EN for fixed m0 priority.
module ahb_cmd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  m0_vld_i,
  output logic                  m0_rdy_o,
  input  logic                  m0_wr_en_i,
  input  logic                  m0_rd_en_i,
  input  logic [2:0]            m0_size_i,
  input  logic [2:0]            m0_burst_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_rsp_vld_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m0_rsp_rdy_i,
  input  logic                  m1_vld_i,
  output logic                  m1_rdy_o,
  input  logic                  m1_wr_en_i,
  input  logic                  m1_rd_en_i,
  input  logic [2:0]            m1_size_i,
  input  logic [2:0]            m1_burst_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_rsp_vld_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  input  logic                  m1_rsp_rdy_i,
  output logic                  din_vld_o,
  input  logic                  din_rdy_i,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic [2:0]            data_size_o,
  output logic [2:0]            burst_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  dout_vld_i,
  output logic                  dout_rdy_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  orphan_rsp_o
);

  localparam int              PTR_W    = $clog2(TAG_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(TAG_DEPTH);

  logic             gnt;
  logic             lock_id;
  logic [3:0]       lock_cnt;
  logic [3:0]       lock_load;
  logic             g_vld, g_wr, g_rd, is_read, read_block, accept;
  logic [2:0]       g_burst;

  logic             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   tag_cnt;
  logic             tag_empty, head, push, pop;

`ifndef ARB_FIXED_PRIO_EN
  logic rr_ptr;
`endif

  // Grant is combinational so a command passes in the cycle it is presented.
  always_comb begin
    if (lock_cnt != 4'd0) begin
      gnt = lock_id;
    end else begin
`ifdef ARB_FIXED_PRIO_EN
      gnt = !m0_vld_i && m1_vld_i;
`else
      if (m0_vld_i && m1_vld_i) gnt = rr_ptr;
      else if (m0_vld_i)        gnt = 1'b0;
      else if (m1_vld_i)        gnt = 1'b1;
      else                      gnt = rr_ptr;
`endif
    end
  end

  assign g_vld       = gnt ? m1_vld_i   : m0_vld_i;
  assign g_wr        = gnt ? m1_wr_en_i : m0_wr_en_i;
  assign g_rd        = gnt ? m1_rd_en_i : m0_rd_en_i;
  assign g_burst     = gnt ? m1_burst_i : m0_burst_i;
  assign wr_en_o     = g_wr;
  assign rd_en_o     = g_rd;
  assign burst_o     = g_burst;
  assign data_size_o = gnt ? m1_size_i  : m0_size_i;
  assign addr_o      = gnt ? m1_addr_i  : m0_addr_i;
  assign wdata_o     = gnt ? m1_wdata_i : m0_wdata_i;

  // A combined wr+rd command is a write and never takes a tag.
  assign is_read    = g_rd && !g_wr;
  assign read_block = is_read && (tag_cnt == FULL_CNT);
  assign din_vld_o  = hresetn && g_vld && !read_block;
  assign accept     = din_vld_o && din_rdy_i;
  assign m0_rdy_o   = accept && !gnt;
  assign m1_rdy_o   = accept && gnt;

  always_comb begin
    case (g_burst[2:1])
      2'b00:   lock_load = 4'd0;
      2'b01:   lock_load = 4'd3;
      2'b10:   lock_load = 4'd7;
      default: lock_load = 4'd15;
    endcase
  end

  assign tag_empty    = (tag_cnt == '0);
  assign head         = tag_mem[rd_ptr];
  assign m0_rsp_vld_o = hresetn && dout_vld_i && !tag_empty && !head;
  assign m1_rsp_vld_o = hresetn && dout_vld_i && !tag_empty && head;
  assign dout_rdy_o   = tag_empty ? 1'b1 : (head ? m1_rsp_rdy_i : m0_rsp_rdy_i);
  assign m0_rdata_o   = rdata_i;
  assign m1_rdata_o   = rdata_i;
  assign push         = accept && is_read;
  assign pop          = dout_vld_i && dout_rdy_o && !tag_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      lock_cnt     <= 4'd0;
      lock_id      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_cnt      <= '0;
      orphan_rsp_o <= 1'b0;
    end else begin
      if (accept) begin
        if (lock_cnt != 4'd0) begin
          lock_cnt <= lock_cnt - 4'd1;
        end else if (lock_load != 4'd0) begin
          lock_cnt <= lock_load;
          lock_id  <= gnt;
        end
      end
      if (dout_vld_i && tag_empty) orphan_rsp_o <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      tag_cnt <= tag_cnt + 1'b1;
      else if (pop && !push) tag_cnt <= tag_cnt - 1'b1;
    end
  end

  // NOTE: tag storage has no reset; entries are only read while counted valid by tag_cnt.
  always_ff @(posedge hclk) begin
    if (push) tag_mem[wr_ptr] <= gnt;
  end

`ifndef ARB_FIXED_PRIO_EN
  logic rr_adv;
  // Priority flips to the other requester once a single or the last burst beat is accepted.
  assign rr_adv = accept && ((lock_cnt == 4'd1) || (lock_cnt == 4'd0 && lock_load == 4'd0));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)    rr_ptr <= 1'b0;
    else if (rr_adv) rr_ptr <= ~gnt;
  end
`endif

endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// Self-checking bench for ahb_cmd_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level model (queue of tags, beat counting).
module tb_ahb_cmd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TD = 4;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          vld [2];
  logic          wr [2];
  logic          rd [2];
  logic [2:0]    size [2];
  logic [2:0]    burst [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          rsp_rdy [2];
  logic          din_rdy_i, dout_vld_i;
  logic [DW-1:0] rdata_i;

  logic          m0_rdy_o, m1_rdy_o, m0_rsp_vld_o, m1_rsp_vld_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          din_vld_o, wr_en_o, rd_en_o, dout_rdy_o, orphan_rsp_o;
  logic [2:0]    data_size_o, burst_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;

  ahb_cmd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_vld_i(vld[0]), .m0_rdy_o(m0_rdy_o), .m0_wr_en_i(wr[0]), .m0_rd_en_i(rd[0]),
    .m0_size_i(size[0]), .m0_burst_i(burst[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
    .m0_rsp_vld_o(m0_rsp_vld_o), .m0_rdata_o(m0_rdata_o), .m0_rsp_rdy_i(rsp_rdy[0]),
    .m1_vld_i(vld[1]), .m1_rdy_o(m1_rdy_o), .m1_wr_en_i(wr[1]), .m1_rd_en_i(rd[1]),
    .m1_size_i(size[1]), .m1_burst_i(burst[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
    .m1_rsp_vld_o(m1_rsp_vld_o), .m1_rdata_o(m1_rdata_o), .m1_rsp_rdy_i(rsp_rdy[1]),
    .din_vld_o(din_vld_o), .din_rdy_i(din_rdy_i), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .data_size_o(data_size_o), .burst_o(burst_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .dout_vld_i(dout_vld_i), .dout_rdy_o(dout_rdy_o), .rdata_i(rdata_i),
    .orphan_rsp_o(orphan_rsp_o)
  );

  always #5 hclk = ~hclk;

  int tests  = 0;
  int failed = 0;

  // Reference model: preferred requester, beats left in a locked burst, queue of read owners.
  int pref, lock_rem, owner;
  int tagq[$];
  bit orph;
  int eg;
  bit e_din_vld, e_acc, e_isrd, e_pop, e_dout_rdy;
  bit e_rdy [2];
  bit e_rsp [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pref = 0; lock_rem = 0; owner = 0; orph = 0;
    tagq.delete();
  endtask

  task automatic idle();
    for (int r = 0; r < 2; r++) begin
      vld[r] = 0; wr[r] = 0; rd[r] = 0; size[r] = 3'd2; burst[r] = 3'd0;
      addr[r] = '0; wdata[r] = '0; rsp_rdy[r] = 0;
    end
    din_rdy_i = 0; dout_vld_i = 0; rdata_i = '0;
  endtask

  task automatic eval_check();
    bit blk;
    int h;
    @(negedge hclk);
    if (lock_rem > 0) eg = owner;
`ifdef ARB_FIXED_PRIO_EN
    else if (vld[0]) eg = 0;
    else if (vld[1]) eg = 1;
    else eg = 0;
`else
    else if (vld[0] && vld[1]) eg = pref;
    else if (vld[0]) eg = 0;
    else if (vld[1]) eg = 1;
    else eg = pref;
`endif
    e_isrd    = rd[eg] && !wr[eg];
    blk       = e_isrd && (tagq.size() == TD);
    e_din_vld = vld[eg] && !blk;
    e_acc     = e_din_vld && din_rdy_i;
    e_rdy[0]  = e_acc && (eg == 0);
    e_rdy[1]  = e_acc && (eg == 1);
    e_rsp[0]  = 0;
    e_rsp[1]  = 0;
    if (tagq.size() == 0) begin
      e_dout_rdy = 1;
    end else begin
      h = tagq[0];
      e_rsp[h]   = dout_vld_i;
      e_dout_rdy = rsp_rdy[h];
    end
    e_pop = (tagq.size() > 0) && dout_vld_i && e_dout_rdy;
    check("din_vld", din_vld_o, e_din_vld);
    check("m0_rdy", m0_rdy_o, e_rdy[0]);
    check("m1_rdy", m1_rdy_o, e_rdy[1]);
    check("m0_rsp_vld", m0_rsp_vld_o, e_rsp[0]);
    check("m1_rsp_vld", m1_rsp_vld_o, e_rsp[1]);
    check("dout_rdy", dout_rdy_o, e_dout_rdy);
    check("orphan", orphan_rsp_o, orph);
    if (e_din_vld) begin
      check("wr_en", wr_en_o, wr[eg]);
      check("rd_en", rd_en_o, rd[eg]);
      check("size", data_size_o, size[eg]);
      check("burst", burst_o, burst[eg]);
      check("addr", addr_o, addr[eg]);
      check("wdata", wdata_o, wdata[eg]);
    end
    if (e_rsp[0]) check("m0_rdata", m0_rdata_o, rdata_i);
    if (e_rsp[1]) check("m1_rdata", m1_rdata_o, rdata_i);
  endtask

  task automatic advance();
    int b, beats;
    @(posedge hclk);
    if (tagq.size() == 0 && dout_vld_i) orph = 1;
    if (e_pop) void'(tagq.pop_front());
    if (e_acc && e_isrd) tagq.push_back(eg);
    if (e_acc) begin
      if (lock_rem > 0) begin
        lock_rem--;
        if (lock_rem == 0) pref = 1 - eg;
      end else begin
        b     = int'(burst[eg]);
        beats = (b < 2) ? 1 : (4 << ((b - 2) / 2));
        if (beats > 1) begin
          lock_rem = beats - 1;
          owner    = eg;
        end else begin
          pref = 1 - eg;
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    eval_check();
    advance();
  endtask

  task automatic do_reset();
    idle();
    hresetn = 0;
    @(negedge hclk);
    hresetn = 1;
    model_reset();
    @(posedge hclk);
    #1;
  endtask

  int order[$];
  bit m1_seen;

  initial begin
    // Reset with every input active: all handshake outputs must stay low.
    idle();
    hresetn = 1;
    vld[0] = 1; vld[1] = 1; wr[0] = 1; wr[1] = 1;
    din_rdy_i = 1; dout_vld_i = 1; rsp_rdy[0] = 1; rsp_rdy[1] = 1;
    #1 hresetn = 0;
    #11;
    check("rst_din_vld", din_vld_o, 0);
    check("rst_m0_rdy", m0_rdy_o, 0);
    check("rst_m1_rdy", m1_rdy_o, 0);
    check("rst_m0_rsp", m0_rsp_vld_o, 0);
    check("rst_m1_rsp", m1_rsp_vld_o, 0);
    check("rst_orphan", orphan_rsp_o, 0);
    idle();
    @(negedge hclk);
    hresetn = 1;
    model_reset();
    @(posedge hclk);
    #1;

    // Both requesters hold SINGLE writes.
    vld[0] = 1; vld[1] = 1; wr[0] = 1; wr[1] = 1; din_rdy_i = 1;
    addr[0] = 32'h1000; addr[1] = 32'h2000;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) begin
      eval_check();
      check("fix_m0_rdy", m0_rdy_o, 1);
      check("fix_m1_rdy", m1_rdy_o, 0);
      advance();
    end
    vld[0] = 0;
    eval_check();
    check("fix_m1_after_drop", m1_rdy_o, 1);
    advance();
`else
    for (int i = 0; i < 4; i++) begin
      eval_check();
      check("alt_m0_rdy", m0_rdy_o, (i % 2) == 0);
      check("alt_m1_rdy", m1_rdy_o, (i % 2) == 1);
      advance();
    end
`endif

    // m0 INCR4 write against a continuously valid m1, din_rdy toggling.
    do_reset();
    vld[0] = 1; wr[0] = 1; burst[0] = 3'd3; addr[0] = 32'h3000;
    vld[1] = 1; wr[1] = 1; burst[1] = 3'd0; addr[1] = 32'h4000;
    order.delete();
    m1_seen = 0;
    for (int i = 0; i < 20 && !m1_seen; i++) begin
      din_rdy_i = (i % 2) == 0;
      eval_check();
      if (m0_rdy_o) order.push_back(0);
      if (m1_rdy_o) begin
        order.push_back(1);
        m1_seen = 1;
      end
      advance();
`ifdef ARB_FIXED_PRIO_EN
      if (order.size() == 4) vld[0] = 0;
`endif
    end
    check("incr4_len", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) check("incr4_order", order[k], k == 4);
    idle();

    // Tag FIFO fill: five reads from m0, no responses.
    vld[0] = 1; rd[0] = 1; din_rdy_i = 1; addr[0] = 32'h5000;
    for (int i = 0; i < 5; i++) begin
      eval_check();
      check("rdfull_rdy", m0_rdy_o, i < 4);
      advance();
    end
    dout_vld_i = 1; rsp_rdy[0] = 1; rdata_i = 32'h55;
    eval_check();
    check("rdfull_popcyc_rdy", m0_rdy_o, 0);
    check("rdfull_popcyc_rsp", m0_rsp_vld_o, 1);
    advance();
    dout_vld_i = 0;
    eval_check();
    check("rdfull_after_pop", m0_rdy_o, 1);
    advance();
    vld[0] = 0;
    dout_vld_i = 1; rsp_rdy[1] = 1;
    for (int i = 0; i < 4; i++) begin
      rdata_i = DW'(32'h60 + i);
      cyc();
    end
    idle();

    // Interleaved reads m0, m1, m0 and in-order response routing.
    din_rdy_i = 1;
    vld[0] = 1; rd[0] = 1; cyc();
    vld[0] = 0; vld[1] = 1; rd[1] = 1; cyc();
    vld[1] = 0; vld[0] = 1; cyc();
    vld[0] = 0;
    dout_vld_i = 1; rsp_rdy[0] = 1; rsp_rdy[1] = 0; rdata_i = 32'hA;
    eval_check();
    check("il_a_vld", m0_rsp_vld_o, 1);
    check("il_a_data", m0_rdata_o, 32'hA);
    advance();
    rdata_i = 32'hB;
    for (int i = 0; i < 2; i++) begin
      eval_check();
      check("il_b_stall", dout_rdy_o, 0);
      check("il_b_vld", m1_rsp_vld_o, 1);
      advance();
    end
    rsp_rdy[1] = 1;
    eval_check();
    check("il_b_rdy", dout_rdy_o, 1);
    check("il_b_data", m1_rdata_o, 32'hB);
    advance();
    rdata_i = 32'hC;
    eval_check();
    check("il_c_vld", m0_rsp_vld_o, 1);
    check("il_c_m1", m1_rsp_vld_o, 0);
    check("il_c_data", m0_rdata_o, 32'hC);
    advance();
    idle();

    // Orphan response straight after reset.
    do_reset();
    dout_vld_i = 1; rdata_i = 32'hDEAD;
    eval_check();
    check("orph_dout_rdy", dout_rdy_o, 1);
    check("orph_m0_rsp", m0_rsp_vld_o, 0);
    check("orph_m1_rsp", m1_rsp_vld_o, 0);
    advance();
    dout_vld_i = 0;
    eval_check();
    check("orph_sticky", orphan_rsp_o, 1);
    advance();

    // Reset in the middle of an INCR8 from m0.
    vld[0] = 1; wr[0] = 1; burst[0] = 3'd5; addr[0] = 32'h7000;
    vld[1] = 1; wr[1] = 1; burst[1] = 3'd0; din_rdy_i = 1;
    for (int i = 0; i < 3; i++) cyc();
    hresetn = 0;
    #1;
    check("midrst_m0_rdy", m0_rdy_o, 0);
    check("midrst_m1_rdy", m1_rdy_o, 0);
    check("midrst_din_vld", din_vld_o, 0);
    idle();
    @(negedge hclk);
    hresetn = 1;
    model_reset();
    @(posedge hclk);
    #1;
    vld[1] = 1; wr[1] = 1; din_rdy_i = 1;
    eval_check();
    check("midrst_lock_clear", m1_rdy_o, 1);
    advance();
    idle();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 2; r++) begin
        vld[r]     = $urandom_range(0, 3) != 0;
        {wr[r], rd[r]} = 2'($urandom);
        size[r]    = 3'($urandom);
        burst[r]   = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
        addr[r]    = $urandom;
        wdata[r]   = $urandom;
        rsp_rdy[r] = $urandom_range(0, 3) != 0;
      end
      din_rdy_i  = $urandom_range(0, 3) != 0;
      dout_vld_i = 1'($urandom_range(0, 1));
      rdata_i    = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
